icache_dm: RTL
==============

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the pipeline fetch stage and the memory controller.
- Acts as responder to the fetch stage: it returns `ihit` and `imemload`, which gate the pipeline registers.
- Acts as initiator toward the memory controller's instruction port (`iREN`, `iaddr`, `iwait`, `iload`).
- Hits complete in the same cycle. Misses run a two-state refill FSM.

Parameters:
- NSETS, 16, number of one-word frames; power of two.
- IDX_W, 4, log2(NSETS); index = `imemaddr[IDX_W+1:2]`.
- TAG_W, 26, 30-IDX_W; tag = `imemaddr[31:IDX_W+2]`.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- imemREN  in  1  fetch stage requests instruction
- imemaddr  in  32  fetch word address; bits [1:0] ignored
- ihit  out  1  `imemload` valid this cycle
- imemload  out  32  instruction word
- iREN  out  1  read request to memory controller
- iaddr  out  32  word address to memory controller; bits [1:0] forced 0
- iwait  in  1  memory busy; 0 = `iload` valid this cycle
- iload  in  32  memory read data

Behaviour:
- Storage: per frame, valid (1b), tag (TAG_W), data (32b).
- Reset (`nRST`=0, async):
  - all valid bits cleared; state=IDLE; miss-address register=0.
  - `iREN`=0, `iaddr`=0, `ihit`=0, `imemload`=0.
  - Tag and data contents need not be reset.
- Lookup (combinational): hit = `imemREN` & valid[idx] & (tag[idx]==addr tag).
- State IDLE:
  - `ihit`=hit; `imemload`=data[idx] when hit, else 0.
  - `iREN`=0, `iaddr`=0.
  - `imemREN` & !hit -> latch `{imemaddr[31:2],2'b00}` into the miss-address register; next state MISS.
  - Otherwise remain in IDLE.
- State MISS:
  - `ihit`=0, `imemload`=0; `iREN`=1; `iaddr`=miss-address register.
  - `iwait`=0 and `imemREN`=1 -> at the clock edge write frame[miss idx] = {valid=1, miss tag, `iload`}; next state IDLE.
  - `imemREN`=0 (any `iwait`) -> abort: no frame write; next state IDLE.
    - `imemREN`=0 takes priority over `iwait`=0 in the same cycle.
  - `iwait`=1 and `imemREN`=1 -> stay in MISS.
- Latency:
  - Hit: 0 cycles, ihit in the request cycle.
  - Miss: ihit earliest 1 cycle after the `iwait`=0 cycle, i.e. (memory wait cycles + 2) cycles after the request cycle.
  - No forwarding of `iload` to `imemload` during the fill cycle.
- Address change during MISS (e.g. branch resolved):
  - Refill completes with the latched address.
  - Back in IDLE the new `imemaddr` is looked up normally; it may miss again.
- Conflict refill overwrites the existing frame unconditionally; no write-back (read-only).
- Back-to-back misses: after returning to IDLE, a new miss enters MISS on the next edge; `iREN` drops for at least one cycle between refills.
- `imemaddr` bits [1:0] never affect index, tag or `iaddr`.
- Reset mid-MISS: immediate return to IDLE with `iREN`=0; the partial refill is discarded and all valid bits are cleared.

Test Plan:
- Cold miss:
  - Stimulus: after reset, `imemREN`=1, `imemaddr`=0x00000040; memory holds `iwait`=1 for 3 cycles, then `iwait`=0 with `iload`=0x8C220004.
  - Required: `ihit`=0 in the request cycle; `iREN`=1 with `iaddr`=0x00000040 for 4 cycles; next cycle `ihit`=1, `imemload`=0x8C220004.
- Repeat hit: same address again with `iwait` held 1 -> `ihit`=1 in the same cycle, `iREN`=0, `imemload`=0x8C220004.
- Conflict eviction:
  - Stimulus: fetch 0x00000040 (data A), then 0x00000080 (same index 0, data B), then 0x00000040 again.
  - Required: second access misses and refills B; third access misses again and returns A after refill.
- Abort:
  - Stimulus: miss on 0x00000100; drop `imemREN` in the same cycle `iwait`=0.
  - Required: no fill occurs; the later request to 0x00000100 misses (`ihit`=0, `iREN`=1).
- Address change mid-miss:
  - Stimulus: miss on 0x00000010; switch `imemaddr` to 0x00000020 before `iwait`=0.
  - Required: `iaddr` stays 0x00000010; frame 4 filled; next cycle lookup of 0x00000020 misses with `iaddr`=0x00000020; afterward 0x00000010 hits.
- Reset mid-operation:
  - Stimulus: assert `nRST`=0 during MISS and after several fills.
  - Required: `iREN` drops asynchronously; after release, all previously cached addresses miss.

Source files
------------

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache with one-word frames.
//
// It sits between the fetch stage and the instruction port of the memory
// controller. A hit returns its data in the cycle it is requested. A miss
// runs a two-state refill: IDLE latches the miss address, and MISS holds
// iREN until the memory delivers the word.
//
// Ports
//   CLK        in   clock, rising edge
//   nRST       in   asynchronous active-low reset
//   imemREN    in   fetch stage requests an instruction
//   imemaddr   in   fetch word address; bits [1:0] are ignored
//   ihit       out  imemload is valid this cycle
//   imemload   out  instruction word (0 when ihit is low)
//   iREN       out  read request to the memory controller
//   iaddr      out  word address to the memory controller; bits [1:0] are 0
//   iwait      in   memory busy; 0 means iload is valid this cycle
//   iload      in   memory read data
//   state_dbg  out  current FSM state (0 = IDLE, 1 = MISS)
//
// Handshake: the fetch stage holds imemREN/imemaddr and advances only in a
// cycle where ihit=1. Toward memory, iREN/iaddr stay stable while iwait=1.
// The word is taken in the first cycle with iwait=0. If imemREN drops
// while a refill is outstanding, the refill is abandoned. This abort takes
// priority over a word arriving in the same cycle.
module icache_dm #(
    parameter int NSETS = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic        state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state, next_state;

    logic [NSETS-1:0] valid;
    logic [TAG_W-1:0] tags [NSETS];
    logic [31:0]      data [NSETS];

    // Only the word address is kept. The byte offset is re-inserted as zero on iaddr.
    logic [29:0]      miss_word;

    logic [IDX_W-1:0] idx, miss_idx;
    logic [TAG_W-1:0] tag, miss_tag;
    logic             hit, fill, latch_miss;
    logic             unused_lsbs;

    assign idx         = imemaddr[IDX_W+1:2];
    assign tag         = imemaddr[31:IDX_W+2];
    assign miss_idx    = miss_word[IDX_W-1:0];
    assign miss_tag    = miss_word[29:IDX_W];
    assign unused_lsbs = ^imemaddr[1:0];

    assign hit        = imemREN & valid[idx] & (tags[idx] == tag);
    assign latch_miss = (state == IDLE) & imemREN & ~hit;
    // A refill is written only if the request is still live when the word arrives.
    assign fill       = (state == MISS) & imemREN & ~iwait;
    assign state_dbg  = state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_word <= '0;
            valid     <= '0;
        end else begin
            state <= next_state;
            if (latch_miss) begin
                miss_word <= imemaddr[31:2];
            end
            if (fill) begin
                valid[miss_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset. The valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[miss_idx] <= miss_tag;
            data[miss_idx] <= iload;
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        case (state)
            IDLE: begin
                ihit     = hit;
                imemload = hit ? data[idx] : 32'h0;
                if (latch_miss) begin
                    next_state = MISS;
                end
            end
            MISS: begin
                iREN  = 1'b1;
                iaddr = {miss_word, 2'b00};
                if (!imemREN || !iwait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
